// File: rtl/dz_rx_silo_scanner.sv
// Purpose : DZ11 receive path - round-robin scans 8 UART receivers and loads chars into the RBUF silo.
// Latency : UART full with the scan pointer on its line -> silo entry visible 2 clk later.
// Backpr. : a full silo drops the char (UART still acked) and flags OVRN on the next stored entry.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   devRESET, csrCLR    synchronous flush (UBA device reset, CSR[CLR] one-shot)
//   csrMSE, csrSAE      master scan enable, silo alarm enable
//   lprRXON[7:0]        per-line receiver enable
//   uartRXFULL/DATA/FE/PE   per-line receive status, char (line n = DATA[8n+7:8n]) and error flags
//   uartRXCLR[7:0]      one-cycle acknowledge to the UART whose char was taken
//   rbufREAD            RBUF read strobe; only its rising edge pops
//   rbufDATA[15:0]      {DVAL,OVRN,FE,PE,0,LINE[2:0],DATA[7:0]} at the silo head, 0 when empty
//   rbufRDONE, rbufSA   silo not empty, silo alarm
//
// Build option: define DZ_SILO_ALARM_EN to include the silo alarm counter;
// otherwise rbufSA is constant 0.

module dz_rx_silo_scanner #(
    parameter int SILO_LOG2 = 6,
    parameter int SA_THRESH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        devRESET,
    input  logic        csrCLR,
    input  logic        csrMSE,
    input  logic        csrSAE,
    input  logic [7:0]  lprRXON,
    input  logic [7:0]  uartRXFULL,
    input  logic [63:0] uartRXDATA,
    input  logic [7:0]  uartRXFE,
    input  logic [7:0]  uartRXPE,
    output logic [7:0]  uartRXCLR,
    input  logic        rbufREAD,
    output logic [15:0] rbufDATA,
    output logic        rbufRDONE,
    output logic        rbufSA
);

    localparam int DEPTH = 1 << SILO_LOG2;
    localparam logic [SILO_LOG2:0] FULL_COUNT = (SILO_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {
        SCAN = 2'd0,
        CAPT = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t                 state;
    logic [2:0]             ptr;
    logic                   ovrnPend;
    logic                   readPrev;

    logic [15:0]            silo [DEPTH];
    logic [SILO_LOG2-1:0]   wrPtr;
    logic [SILO_LOG2-1:0]   rdPtr;
    logic [SILO_LOG2:0]     count;
    logic [SILO_LOG2:0]     countNext;

    logic                   flush;
    logic                   siloFull;
    logic                   popEn;
    logic                   wrEn;
    logic                   dropEn;
    logic [7:0]             curData;
    logic [15:0]            wrWord;

    // Both flush sources behave exactly like reset but are sampled on the clock.
    assign flush    = devRESET | csrCLR;
    assign siloFull = (count == FULL_COUNT);

    // A held read strobe pops only once: act on its first cycle.
    assign popEn    = rbufREAD & ~readPrev & (count != '0);

    // A pop in the same cycle frees a slot, so a capture into a full silo
    // still succeeds when the head is leaving at the same time.
    assign wrEn     = (state == CAPT) & (~siloFull | popEn);
    assign dropEn   = (state == CAPT) & siloFull & ~popEn;

    assign curData  = uartRXDATA[{ptr, 3'b000} +: 8];
    assign wrWord   = {1'b1, ovrnPend, uartRXFE[ptr], uartRXPE[ptr], 1'b0, ptr, curData};

    always_comb begin
        countNext = count;
        if (wrEn && !popEn) begin
            countNext = count + 1'b1;
        end else if (!wrEn && popEn) begin
            countNext = count - 1'b1;
        end
    end

    // Silo storage: contents need no reset, validity is carried by count.
    always_ff @(posedge clk) begin
        if (wrEn && !flush) begin
            silo[wrPtr] <= wrWord;
        end
    end

    // Head is presented combinationally; DVAL=0 word when the silo is empty.
    assign rbufDATA = rbufRDONE ? silo[rdPtr] : 16'h0000;

    // Scanner FSM, silo pointers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SCAN;
            ptr       <= 3'd0;
            ovrnPend  <= 1'b0;
            readPrev  <= 1'b0;
            wrPtr     <= '0;
            rdPtr     <= '0;
            count     <= '0;
            rbufRDONE <= 1'b0;
            uartRXCLR <= 8'h00;
        end else if (flush) begin
            state     <= SCAN;
            ptr       <= 3'd0;
            ovrnPend  <= 1'b0;
            // Keep tracking the strobe so a read held across the flush does
            // not look like a fresh edge afterwards.
            readPrev  <= rbufREAD;
            wrPtr     <= '0;
            rdPtr     <= '0;
            count     <= '0;
            rbufRDONE <= 1'b0;
            uartRXCLR <= 8'h00;
        end else begin
            readPrev  <= rbufREAD;
            uartRXCLR <= 8'h00;

            case (state)
                SCAN: begin
                    if (csrMSE && lprRXON[ptr] && uartRXFULL[ptr]) begin
                        state     <= CAPT;
                        // Ack goes out during the capture cycle itself.
                        uartRXCLR <= 8'b0000_0001 << ptr;
                    end else if (csrMSE) begin
                        ptr <= ptr + 3'd1;
                    end
                end
                CAPT: begin
                    state <= WAIT;
                    if (wrEn) begin
                        ovrnPend <= 1'b0;
                    end else if (dropEn) begin
                        ovrnPend <= 1'b1;
                    end
                end
                WAIT: begin
                    // The UART needs a cycle to drop FULL after the ack;
                    // moving on earlier would recapture the same char.
                    if (!uartRXFULL[ptr]) begin
                        ptr   <= ptr + 3'd1;
                        state <= SCAN;
                    end
                end
                default: begin
                    state <= SCAN;
                end
            endcase

            if (wrEn) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (popEn) begin
                rdPtr <= rdPtr + 1'b1;
            end
            count     <= countNext;
            rbufRDONE <= (countNext != '0);
        end
    end

`ifdef DZ_SILO_ALARM_EN
    localparam int SA_W = $clog2(SA_THRESH + 1);

    logic [SA_W-1:0] saCount;

    // Counts writes since the last pop; the alarm is sticky until a pop or
    // until the alarm is disabled, and the count saturates at the threshold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            saCount <= '0;
            rbufSA  <= 1'b0;
        end else if (flush || !csrSAE || popEn) begin
            saCount <= '0;
            rbufSA  <= 1'b0;
        end else if (wrEn && (saCount != SA_W'(SA_THRESH))) begin
            saCount <= saCount + 1'b1;
            if (saCount == SA_W'(SA_THRESH - 1)) begin
                rbufSA <= 1'b1;
            end
        end
    end
`else
    // No alarm hardware: the expression folds to 0 but keeps the alarm
    // controls referenced in this build.
    assign rbufSA = 1'b0 & csrSAE & (SA_THRESH != 0);
`endif

endmodule

// File: tb/tb_dz_rx_silo_scanner.sv
module tb_dz_rx_silo_scanner;

    logic        clk = 1'b0;
    logic        rst;
    logic        devRESET;
    logic        csrCLR;
    logic        csrMSE;
    logic        csrSAE;
    logic [7:0]  lprRXON;
    logic [7:0]  uartRXFULL;
    logic [63:0] uartRXDATA;
    logic [7:0]  uartRXFE;
    logic [7:0]  uartRXPE;
    logic [7:0]  uartRXCLR;
    logic        rbufREAD;
    logic [15:0] rbufDATA;
    logic        rbufRDONE;
    logic        rbufSA;

    int checks   = 0;
    int failures = 0;

    logic [15:0] expQ[$];

    dz_rx_silo_scanner #(.SILO_LOG2(6), .SA_THRESH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .devRESET   (devRESET),
        .csrCLR     (csrCLR),
        .csrMSE     (csrMSE),
        .csrSAE     (csrSAE),
        .lprRXON    (lprRXON),
        .uartRXFULL (uartRXFULL),
        .uartRXDATA (uartRXDATA),
        .uartRXFE   (uartRXFE),
        .uartRXPE   (uartRXPE),
        .uartRXCLR  (uartRXCLR),
        .rbufREAD   (rbufREAD),
        .rbufDATA   (rbufDATA),
        .rbufRDONE  (rbufRDONE),
        .rbufSA     (rbufSA)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Monitor: every rising edge of the read strobe presents the head word;
    // compare it against the oldest expected entry.
    logic monPrev = 1'b0;
    always @(negedge clk) begin
        logic [15:0] e;
        if (rbufREAD && !monPrev) begin
            if (rbufRDONE) begin
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL pop_extra: got %h, required no entry", rbufDATA);
                end else begin
                    e = expQ.pop_front();
                    check("pop_data", {16'h0, rbufDATA}, {16'h0, e});
                end
            end else begin
                check("pop_empty_data", {16'h0, rbufDATA}, 32'h0);
            end
        end
        monPrev = rbufREAD;
    end

    // Inputs change 2 time units after the rising edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic setChar(input int line, input logic [7:0] d, input bit fe, input bit pe);
        uartRXDATA[line*8 +: 8] = d;
        uartRXFE[line]          = fe;
        uartRXPE[line]          = pe;
        uartRXFULL[line]        = 1'b1;
    endtask

    // UART model: a line drops FULL on the cycle after its ack is seen.
    task automatic serviceAll(input int budget, output int pulses, output int firstAt,
                              output logic [7:0] firstClr);
        logic [7:0] pend;
        int c;
        pulses   = 0;
        firstAt  = 0;
        firstClr = 8'h00;
        c        = 0;
        while (uartRXFULL != 8'h00 && c < budget) begin
            c++;
            @(negedge clk);
            pend = uartRXCLR;
            if (pend != 8'h00) begin
                pulses++;
                if (firstAt == 0) begin
                    firstAt  = c;
                    firstClr = pend;
                end
            end
            @(posedge clk);
            #2;
            uartRXFULL = uartRXFULL & ~pend;
        end
        if (uartRXFULL != 8'h00) begin
            checks++;
            failures++;
            $display("FAIL service_timeout: lines still full %h, required 00", uartRXFULL);
            uartRXFULL = 8'h00;
        end
        repeat (3) begin
            @(negedge clk);
            if (uartRXCLR != 8'h00) pulses++;
            @(posedge clk);
            #2;
        end
    endtask

    task automatic sendChar(input int line, input logic [7:0] d, input bit fe, input bit pe,
                            input bit store, input logic [15:0] expv);
        int p, f;
        logic [7:0] c;
        setChar(line, d, fe, pe);
        if (store) expQ.push_back(expv);
        serviceAll(60, p, f, c);
        uartRXFE[line] = 1'b0;
        uartRXPE[line] = 1'b0;
    endtask

    task automatic popN(input int n);
        repeat (n) begin
            rbufREAD = 1'b1;
            tick(1);
            rbufREAD = 1'b0;
            tick(1);
        end
    endtask

    task automatic pulseClr();
        csrCLR = 1'b1;
        tick(1);
        csrCLR = 1'b0;
        expQ.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int p, f, n;
        logic [7:0] c;
        bit seen;

        rst        = 1'b1;
        devRESET   = 1'b0;
        csrCLR     = 1'b0;
        csrMSE     = 1'b0;
        csrSAE     = 1'b0;
        lprRXON    = 8'h00;
        uartRXFULL = 8'h00;
        uartRXDATA = 64'h0;
        uartRXFE   = 8'h00;
        uartRXPE   = 8'h00;
        rbufREAD   = 1'b0;
        tick(1);
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_rdone", {31'h0, rbufRDONE}, 32'h0);
        check("rst_data",  {16'h0, rbufDATA},  32'h0);
        check("rst_clr",   {24'h0, uartRXCLR}, 32'h0);
        check("rst_sa",    {31'h0, rbufSA},    32'h0);
        tick(1);

        // 1: single line enabled, one char
        csrMSE  = 1'b1;
        lprRXON = 8'h04;
        setChar(2, 8'h41, 1'b0, 1'b0);
        expQ.push_back(16'h8241);
        serviceAll(60, p, f, c);
        check("t1_clr_val",    {24'h0, c}, 32'h04);
        check("t1_clr_pulses", p, 1);
        @(negedge clk);
        check("t1_rdone", {31'h0, rbufRDONE}, 32'h1);
        check("t1_head",  {16'h0, rbufDATA},  32'h8241);
        tick(1);
        popN(1);
        @(negedge clk);
        check("t1_rdone_after_pop", {31'h0, rbufRDONE}, 32'h0);
        tick(1);

        // 2: lines 1 and 5 full together, scan starting at line 0
        lprRXON = 8'hFF;
        csrCLR  = 1'b1;
        tick(1);
        csrCLR = 1'b0;
        expQ.delete();
        setChar(1, 8'h31, 1'b0, 1'b0);
        setChar(5, 8'h35, 1'b0, 1'b0);
        expQ.push_back(16'h8131);
        expQ.push_back(16'h8535);
        serviceAll(60, p, f, c);
        check("t2_first_clr", {24'h0, c}, 32'h02);
        popN(2);
        @(negedge clk);
        check("t2_data_empty",  {16'h0, rbufDATA},  32'h0);
        check("t2_rdone_empty", {31'h0, rbufRDONE}, 32'h0);
        tick(1);
        popN(1);   // pop of an empty silo: monitor expects a zero word

        // 3: fill to 64, drop one, pop one, next entry carries OVRN
        for (int i = 0; i < 64; i++) begin
            sendChar(3, 8'(i), 1'b0, 1'b0, 1'b1, 16'h8300 | 16'(i));
        end
        @(negedge clk);
        check("t3_full_rdone", {31'h0, rbufRDONE}, 32'h1);
        tick(1);
        sendChar(3, 8'h55, 1'b0, 1'b0, 1'b0, 16'h0);
        popN(1);
        sendChar(3, 8'h56, 1'b0, 1'b0, 1'b1, 16'hC356);
        n = expQ.size();
        check("t3_queue_len", n, 64);
        popN(n);
        @(negedge clk);
        check("t3_drained", {31'h0, rbufRDONE}, 32'h0);
        tick(1);

        // 4: silo alarm threshold
        pulseClr();
        csrSAE = 1'b1;
        for (int i = 0; i < 15; i++) begin
            sendChar(7, 8'h70 + 8'(i), 1'b0, 1'b0, 1'b1, 16'h8770 + 16'(i));
        end
        @(negedge clk);
        check("t4_sa_15", {31'h0, rbufSA}, 32'h0);
        tick(1);
        sendChar(7, 8'h7F, 1'b0, 1'b0, 1'b1, 16'h877F);
        @(negedge clk);
`ifdef DZ_SILO_ALARM_EN
        check("t4_sa_16", {31'h0, rbufSA}, 32'h1);
`else
        check("t4_sa_16", {31'h0, rbufSA}, 32'h0);
`endif
        tick(1);
        popN(1);
        @(negedge clk);
        check("t4_sa_after_pop", {31'h0, rbufSA}, 32'h0);
        tick(1);
        csrSAE = 1'b0;
        popN(expQ.size());

        // 5: read held 5 clocks pops exactly once; FE/PE flags carried
        pulseClr();
        sendChar(6, 8'h61, 1'b0, 1'b0, 1'b1, 16'h8661);
        sendChar(6, 8'h62, 1'b0, 1'b0, 1'b1, 16'h8662);
        sendChar(6, 8'h63, 1'b1, 1'b1, 1'b1, 16'hB663);
        rbufREAD = 1'b1;
        tick(5);
        rbufREAD = 1'b0;
        @(negedge clk);
        check("t5_head_after_hold", {16'h0, rbufDATA},  32'h8662);
        check("t5_rdone",           {31'h0, rbufRDONE}, 32'h1);
        tick(1);
        popN(2);
        @(negedge clk);
        check("t5_empty", {31'h0, rbufRDONE}, 32'h0);
        tick(1);

        // 6: CLR during a capture flushes silo and restarts the scan at line 0
        pulseClr();
        for (int i = 0; i < 10; i++) begin
            sendChar(2, 8'hA0 + 8'(i), 1'b0, 1'b0, 1'b1, 16'h82A0 + 16'(i));
        end
        setChar(0, 8'hAA, 1'b0, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (uartRXCLR[0]) seen = 1'b1;
        end
        check("t6_capt_reached", {31'h0, seen}, 32'h1);
        csrCLR = 1'b1;
        tick(1);
        csrCLR        = 1'b0;
        csrMSE        = 1'b0;
        uartRXFULL[0] = 1'b0;
        expQ.delete();
        @(negedge clk);
        check("t6_rdone", {31'h0, rbufRDONE}, 32'h0);
        check("t6_data",  {16'h0, rbufDATA},  32'h0);
        check("t6_clr",   {24'h0, uartRXCLR}, 32'h0);
        tick(2);
        // Scan frozen at line 0: line 4 is reached on the 5th scan step.
        setChar(4, 8'h44, 1'b0, 1'b0);
        csrMSE = 1'b1;
        expQ.push_back(16'h8444);
        serviceAll(60, p, f, c);
        check("t6_ptr0_latency", f, 6);
        popN(1);
        @(negedge clk);
        check("t6_final_empty", {31'h0, rbufRDONE}, 32'h0);
        check("t6_queue_left",  expQ.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
